// File: rtl/dircc_board_io_pkg.sv
// Register map, field widths and bus command type for the board I/O Avalon-MM responder.
// DIRCC_BOARD_IO_HEXDEC_EN selects nibble+blank HEX storage instead of raw segments.
package dircc_board_io_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int SW_W       = 10;
  localparam int KEY_W      = 4;
  localparam int LEDR_W     = 10;
  localparam int SEG_W      = 7;

  typedef enum logic [2:0] {
    ADDR_HEX_A     = 3'd0,
    ADDR_HEX_B     = 3'd1,
    ADDR_LEDR      = 3'd2,
    ADDR_SW        = 3'd3,
    ADDR_KEY_EDGE  = 3'd4,
    ADDR_IRQ_MASK  = 3'd5,
    ADDR_KEY_STATE = 3'd6,
    ADDR_RSVD      = 3'd7
  } reg_addr_e;

`ifdef DIRCC_BOARD_IO_HEXDEC_EN
  // [4] blank, [3:0] hex nibble
  localparam int                HEX_FW  = 5;
  localparam logic [HEX_FW-1:0] HEX_RST = 5'h10;
`else
  localparam int                HEX_FW  = 7;
  localparam logic [HEX_FW-1:0] HEX_RST = 7'h7F;
`endif

  typedef struct packed {
    logic        rd;
    logic        wr;
    reg_addr_e   addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } avs_cmd_t;
endpackage

// File: rtl/dircc_hex7seg.sv
// Hex nibble to active-low seven-segment pattern (bit 0 = segment a .. bit 6 = g).
module dircc_hex7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = 7'h7F;
    case (nib)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end
endmodule

// File: rtl/dircc_board_io_avs.sv
// Avalon-MM responder for board switches, keys, LEDs and six HEX digits with key-edge irq.
// Build option: DIRCC_BOARD_IO_HEXDEC_EN (hex nibble decode instead of raw segments).
module dircc_board_io_avs
  import dircc_board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  input  logic [9:0]  sw_in,
  input  logic [3:0]  key_n_in,
  output logic [41:0] hex_n,
  output logic [9:0]  ledr,
  output logic        irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  avs_cmd_t cmd;
  // A write wins over a simultaneous read.
  assign cmd = '{rd: avs_read & ~avs_write, wr: avs_write, addr: reg_addr_e'(avs_address),
                 wdata: avs_writedata, be: avs_byteenable};
  assign avs_waitrequest = 1'b0;

  logic [SW_W-1:0]  sw_s1, sw_s2, sw_smp, sw_deb, sw_deb_nxt;
  logic [KEY_W-1:0] key_s1, key_s2, key_smp, key_deb, key_deb_nxt, key_fall;
  logic [CW-1:0]    pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      sw_smp  <= '0;
      sw_deb  <= '0;
      key_s1  <= '1;
      key_s2  <= '1;
      key_smp <= '1;
      key_deb <= '1;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      sw_s1   <= sw_in;
      sw_s2   <= sw_s1;
      key_s1  <= key_n_in;
      key_s2  <= key_s1;
      sw_deb  <= sw_deb_nxt;
      key_deb <= key_deb_nxt;
      if (tick) begin
        sw_smp  <= sw_s2;
        key_smp <= key_s2;
      end
    end
  end

  // A bit follows its synchronizer only when this tick's sample matches the previous tick's.
  always_comb begin
    sw_deb_nxt  = sw_deb;
    key_deb_nxt = key_deb;
    if (tick) begin
      sw_deb_nxt  = (sw_deb & (sw_s2 ^ sw_smp)) | (sw_s2 & ~(sw_s2 ^ sw_smp));
      key_deb_nxt = (key_deb & (key_s2 ^ key_smp)) | (key_s2 & ~(key_s2 ^ key_smp));
    end
  end

  assign key_fall = key_deb & ~key_deb_nxt;

  logic [NUM_DIGITS-1:0][HEX_FW-1:0] hex_q;
  logic [LEDR_W-1:0]                 ledr_q;
  logic [KEY_W-1:0]                  key_edge, irq_mask, w1c;

  assign w1c = (cmd.wr && cmd.addr == ADDR_KEY_EDGE && cmd.be[0]) ? cmd.wdata[KEY_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q    <= {NUM_DIGITS{HEX_RST}};
      ledr_q   <= '0;
      key_edge <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      key_edge <= (key_edge & ~w1c) | key_fall;
      irq      <= |(key_edge & irq_mask);
      if (cmd.wr) begin
        case (cmd.addr)
          ADDR_HEX_A:
            for (int b = 0; b < 4; b++)
              if (cmd.be[b]) hex_q[b] <= cmd.wdata[8*b +: HEX_FW];
          ADDR_HEX_B:
            for (int b = 0; b < NUM_DIGITS-4; b++)
              if (cmd.be[b]) hex_q[4+b] <= cmd.wdata[8*b +: HEX_FW];
          ADDR_LEDR: begin
            if (cmd.be[0]) ledr_q[7:0]        <= cmd.wdata[7:0];
            if (cmd.be[1]) ledr_q[LEDR_W-1:8] <= cmd.wdata[LEDR_W-1:8];
          end
          ADDR_IRQ_MASK: if (cmd.be[0]) irq_mask <= cmd.wdata[KEY_W-1:0];
          default: ;
        endcase
      end
    end
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (cmd.addr)
      ADDR_HEX_A:
        for (int d = 0; d < 4; d++) rd_mux[8*d +: HEX_FW] = hex_q[d];
      ADDR_HEX_B:
        for (int d = 0; d < NUM_DIGITS-4; d++) rd_mux[8*d +: HEX_FW] = hex_q[4+d];
      ADDR_LEDR:      rd_mux[LEDR_W-1:0] = ledr_q;
      ADDR_SW:        rd_mux[SW_W-1:0]   = sw_deb;
      ADDR_KEY_EDGE:  rd_mux[KEY_W-1:0]  = key_edge;
      ADDR_IRQ_MASK:  rd_mux[KEY_W-1:0]  = irq_mask;
      ADDR_KEY_STATE: rd_mux[KEY_W-1:0]  = ~key_deb;
      default: ;
    endcase
  end

  // Read data is driven only in the valid cycle and is zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
    end else begin
      avs_readdatavalid <= cmd.rd;
      avs_readdata      <= cmd.rd ? rd_mux : '0;
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
`ifdef DIRCC_BOARD_IO_HEXDEC_EN
    logic [SEG_W-1:0] seg_n;
    dircc_hex7seg u_dec (.nib(hex_q[d][3:0]), .seg_n(seg_n));
    assign hex_n[SEG_W*d +: SEG_W] = hex_q[d][4] ? {SEG_W{1'b1}} : seg_n;
`else
    assign hex_n[SEG_W*d +: SEG_W] = hex_q[d];
`endif
  end

  assign ledr = ledr_q;

  logic unused_wdata;
  assign unused_wdata = ^cmd.wdata;
endmodule
